csi_raw8_word_packer: RTL and testbench

//  Sits between the MIPI CSI-2 lane deskew/packet parser and the dual-clock frame RAM.

---
 rtl/csi_pkg.sv | 12 +
 rtl/csi_raw8_word_packer.sv | 141 ++++++++++++++
 tb/tb_csi_raw8_word_packer.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/csi_pkg.sv
// Shared CSI-2 receiver definitions: packer FSM state encoding and packet data-type codes.
package csi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } csi_state_e;

    localparam logic [7:0] RAW8 = 8'h2A;

endpackage : csi_pkg

// File: rtl/csi_raw8_word_packer.sv
// Packs RAW8 lane-pair bytes into 32-bit frame-RAM words with raster-aligned addressing;
// clips overlong/excess lines and flushes half words on short lines.
module csi_raw8_word_packer
    import csi_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 17
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              frame_end,
    input  logic              line_end,
    input  logic              byte_valid,
    input  logic [15:0]       byte_data,
    output logic [31:0]       data_o,
    output logic [ADDR_W-1:0] adress_out,
    output logic              we_o,
    output logic              frame_done,
    output logic              frame_err,
    output logic [9:0]        line_cnt
);

    localparam int                PIX_W      = $clog2(H_ACTIVE) + 1;
    localparam logic [PIX_W-1:0]  H_LIM      = PIX_W'(H_ACTIVE);
    localparam logic [PIX_W-1:0]  PAIR_STEP  = PIX_W'(2);
    localparam logic [ADDR_W-1:0] LINE_WORDS = ADDR_W'(H_ACTIVE / 4);
    localparam logic [9:0]        V_LIM      = 10'(V_ACTIVE);
    localparam logic [9:0]        V_LAST     = 10'(V_ACTIVE - 1);

    csi_state_e        state_q, state_d;
    logic [PIX_W-1:0]  pix_cnt;
    logic [ADDR_W-1:0] line_base;
    logic [15:0]       half_data;
    logic              half_valid;

    logic              restart;
    logic              accept;
    logic              close_line;
    logic              wr_en;
    logic [31:0]       wr_word;
    logic [ADDR_W-1:0] wr_addr;

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        restart    = 1'b0;
        accept     = 1'b0;
        close_line = 1'b0;
        wr_en      = 1'b0;
        wr_word    = '0;

        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    restart = 1'b1;
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (frame_start) begin
                    restart = 1'b1;
                end else begin
                    accept     = byte_valid && (pix_cnt < H_LIM) && (line_cnt < V_LIM);
                    close_line = line_end;
                    if (frame_end || (line_end && line_cnt == V_LAST))
                        state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // A pending half is completed by the next pair, or zero-padded when the line closes.
        if (accept && half_valid) begin
            wr_en   = 1'b1;
            wr_word = {byte_data, half_data};
        end else if (accept && close_line) begin
            wr_en   = 1'b1;
            wr_word = {16'h0000, byte_data};
        end else if (half_valid && close_line) begin
            wr_en   = 1'b1;
            wr_word = {16'h0000, half_data};
        end
    end

    assign wr_addr = line_base + ADDR_W'(pix_cnt >> 2);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            pix_cnt    <= '0;
            line_base  <= '0;
            half_data  <= '0;
            half_valid <= 1'b0;
            line_cnt   <= '0;
            data_o     <= '0;
            adress_out <= '0;
            we_o       <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state_q    <= state_d;
            we_o       <= wr_en;
            frame_err  <= restart && (state_q == ST_ACTIVE);
            frame_done <= (state_q == ST_ACTIVE) && (state_d == ST_DONE);

            if (wr_en) begin
                data_o     <= wr_word;
                adress_out <= wr_addr;
            end

            if (restart) begin
                pix_cnt    <= '0;
                line_cnt   <= '0;
                line_base  <= '0;
                half_valid <= 1'b0;
            end else begin
                if (accept) begin
                    pix_cnt <= pix_cnt + PAIR_STEP;
                    if (!half_valid) begin
                        half_data  <= byte_data;
                        half_valid <= 1'b1;
                    end else begin
                        half_valid <= 1'b0;
                    end
                end
                // Closing the line overrides the pair bookkeeping above.
                if (close_line) begin
                    pix_cnt    <= '0;
                    half_valid <= 1'b0;
                    line_cnt   <= line_cnt + 10'd1;
                    line_base  <= line_base + LINE_WORDS;
                end
            end
        end
    end

endmodule : csi_raw8_word_packer

// File: tb/tb_csi_raw8_word_packer.sv
// Self-checking bench for csi_raw8_word_packer: directed scenarios plus random frames
// checked against a line-level reference model of the expected RAM writes.
module tb_csi_raw8_word_packer;

    localparam int H  = 8;
    localparam int V  = 2;
    localparam int AW = 5;

    logic          sys_clk = 1'b0;
    logic          reset   = 1'b0;
    logic          frame_start = 1'b0;
    logic          frame_end   = 1'b0;
    logic          line_end    = 1'b0;
    logic          byte_valid  = 1'b0;
    logic [15:0]   byte_data   = '0;
    logic [31:0]   data_o;
    logic [AW-1:0] adress_out;
    logic          we_o;
    logic          frame_done;
    logic          frame_err;
    logic [9:0]    line_cnt;

    csi_raw8_word_packer #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .ADDR_W   (AW)
    ) dut (
        .sys_clk     (sys_clk),
        .reset       (reset),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .line_end    (line_end),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .data_o      (data_o),
        .adress_out  (adress_out),
        .we_o        (we_o),
        .frame_done  (frame_done),
        .frame_err   (frame_err),
        .line_cnt    (line_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [63:0] obs_q[$];
    logic [63:0] exp_q[$];
    logic [15:0] cur_pairs[$];
    int          model_line  = 0;
    int          done_seen   = 0;
    int          err_seen    = 0;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [63:0] pack(input int addr, input logic [31:0] w);
        logic [63:0] r;
        r          = '0;
        r[31:0]    = w;
        r[32+:AW]  = AW'(addr);
        return r;
    endfunction

    // Reference model: a line's pixels land at line*H/4 + word index, clipped to H pixels
    // and V lines; a trailing half word is zero-padded only when the line is closed.
    task automatic emit(input bit pad);
        int np;
        if (model_line < V) begin
            np = cur_pairs.size();
            if (np > H / 2) np = H / 2;
            for (int k = 0; 2 * k < np; k++) begin
                logic [15:0] lo, hi;
                lo = cur_pairs[2 * k];
                if (2 * k + 1 < np) hi = cur_pairs[2 * k + 1];
                else if (pad)       hi = 16'h0000;
                else                break;
                exp_q.push_back(pack(model_line * (H / 4) + k, {hi, lo}));
            end
        end
        cur_pairs.delete();
    endtask

    task automatic close_model();
        emit(1'b1);
        model_line++;
    endtask

    task automatic abort_model();
        emit(1'b0);
        model_line = 0;
    endtask

    task automatic step(input bit fs, input bit fe, input bit le, input bit bv, input logic [15:0] d);
        frame_start = fs;
        frame_end   = fe;
        line_end    = le;
        byte_valid  = bv;
        byte_data   = d;
        @(posedge sys_clk);
        #1;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        line_end    = 1'b0;
        byte_valid  = 1'b0;
        byte_data   = '0;
        if (we_o === 1'b1) obs_q.push_back(pack(int'(adress_out), data_o));
        if (frame_done === 1'b1) done_seen++;
        if (frame_err === 1'b1)  err_seen++;
    endtask

    task automatic pair(input logic [15:0] d);
        cur_pairs.push_back(d);
        step(1'b0, 1'b0, 1'b0, 1'b1, d);
    endtask

    task automatic send_pairs(input int n, input int b, input bit rnd, input bit gaps, input bit le_last);
        logic [15:0] d;
        for (int i = 0; i < n; i++) begin
            if (gaps && ($urandom % 3 == 0)) step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
            d = rnd ? 16'($urandom) : {8'(b + 2 * i + 1), 8'(b + 2 * i)};
            cur_pairs.push_back(d);
            step(1'b0, 1'b0, le_last && (i == n - 1), 1'b1, d);
        end
    endtask

    task automatic send_line(input int n, input int b, input bit rnd, input bit merge, input bit gaps);
        send_pairs(n, b, rnd, gaps, merge);
        if (!(merge && n > 0)) step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        close_model();
    endtask

    task automatic start_frame();
        done_seen  = 0;
        err_seen   = 0;
        model_line = 0;
        cur_pairs.delete();
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    task automatic check_writes(input string tag);
        int n;
        check({tag, " write count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, " write"}, obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic finish_frame(input string tag, input int exp_done, input int exp_err);
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        check({tag, " frame_done pulses"}, 64'(done_seen), 64'(exp_done));
        check({tag, " frame_err pulses"}, 64'(err_seen), 64'(exp_err));
        check_writes(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #12;
        check("reset data_o", data_o, 0);
        check("reset adress_out", adress_out, 0);
        check("reset we_o", we_o, 0);
        check("reset frame_done", frame_done, 0);
        check("reset frame_err", frame_err, 0);
        check("reset line_cnt", line_cnt, 0);
        @(negedge sys_clk);
        reset = 1'b1;

        // T1: two full lines, word latency, frame end
        start_frame();
        pair(16'h0100);
        check("t1 we after 1st pair", we_o, 0);
        pair(16'h0302);
        check("t1 we after 2nd pair", we_o, 1);
        check("t1 first word", data_o, 32'h03020100);
        check("t1 first addr", adress_out, 0);
        send_pairs(2, 4, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        close_model();
        check("t1 line_cnt after LE", line_cnt, 1);
        send_line(4, 8, 1'b0, 1'b0, 1'b0);
        check("t1 frame_done on last LE", frame_done, 1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        check("t1 frame_done one cycle", frame_done, 0);
        finish_frame("t1", 1, 0);

        // T2: overlong line clipped
        start_frame();
        send_line(6, 0, 1'b0, 1'b0, 1'b0);
        send_line(4, 8, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        finish_frame("t2", 1, 0);

        // T3: short line flushes a padded half word
        start_frame();
        send_pairs(3, 0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        close_model();
        check("t3 flush word", data_o, 32'h00000504);
        check("t3 flush addr", adress_out, 1);
        send_line(4, 8, 1'b0, 1'b0, 1'b0);
        finish_frame("t3", 1, 0);

        // T4: frame_start mid-frame (with a simultaneous pair) restarts at address 0
        start_frame();
        send_line(4, 0, 1'b0, 1'b0, 1'b0);
        send_pairs(2, 8, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 16'hDEAD);
        abort_model();
        check("t4 frame_err", frame_err, 1);
        send_pairs(2, 8'h40, 1'b0, 1'b0, 1'b0);
        check("t4 restart addr", adress_out, 0);
        check("t4 restart we", we_o, 1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        close_model();
        send_line(4, 8'h50, 1'b0, 1'b0, 1'b0);
        finish_frame("t4", 1, 1);

        // T5: asynchronous reset mid-word, then IDLE ignores bytes
        start_frame();
        send_line(4, 0, 1'b0, 1'b0, 1'b0);
        pair(16'hAAAA);
        #3;
        reset = 1'b0;
        #1;
        abort_model();
        check("t5 async data_o", data_o, 0);
        check("t5 async adress_out", adress_out, 0);
        check("t5 async we_o", we_o, 0);
        check("t5 async line_cnt", line_cnt, 0);
        @(negedge sys_clk);
        reset = 1'b1;
        check_writes("t5 pre-reset");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 16'(16'h1111 * (i + 1)));
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        done_seen = 0;
        err_seen  = 0;
        finish_frame("t5 idle", 0, 0);
        start_frame();
        send_line(4, 8'h60, 1'b0, 1'b0, 1'b0);
        send_line(4, 8'h70, 1'b0, 1'b0, 1'b0);
        finish_frame("t5 after", 1, 0);

        // T6: excess line dropped, DONE on LE of the last line, FE ignored
        start_frame();
        send_line(4, 0, 1'b0, 1'b0, 1'b0);
        send_line(4, 8, 1'b0, 1'b0, 1'b0);
        send_line(4, 16, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        finish_frame("t6", 1, 0);

        // T7: line_end with frame_end, and pair with line_end
        start_frame();
        send_pairs(3, 0, 1'b0, 1'b0, 1'b1);
        close_model();
        check("t7 merged flush", data_o, 32'h00000504);
        send_pairs(2, 8, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
        close_model();
        check("t7 le+fe done", frame_done, 1);
        finish_frame("t7", 1, 0);

        // Random frames
        for (int f = 0; f < 40; f++) begin
            int nl;
            nl = $urandom_range(0, 3);
            start_frame();
            for (int l = 0; l < nl; l++)
                send_line($urandom_range(0, 6), 0, 1'b1, 1'($urandom % 2), 1'($urandom % 2));
            step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
            finish_frame("rnd", 1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_csi_raw8_word_packer
